// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared mode/state encodings and constants for the LED mode controller.
package led_ctrl_pkg;
  typedef enum logic [1:0] {LED_OFF, LED_PASS, LED_CHASE, LED_BLINK} led_mode_e;
  typedef enum logic {CFG_RUN, CFG_APPLY} cfg_state_e;
  localparam logic [3:0] CHASE_INIT = 4'b0001;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: base-tick prescaler and pattern-step counter.
module led_tick_gen #(
  parameter int TICK_DIV   = 100000,
  parameter int STEP_TICKS = 250
) (
  input  logic clk,
  input  logic aresetn,
  input  logic step_clr,
  output logic tick,
  output logic step
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(STEP_TICKS - 1);
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_step;
  assign tick = r_presc == P_MAX;
  assign step = tick && r_step == S_MAX;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      r_presc <= '0;
      r_step  <= '0;
    end else begin
      r_presc <= tick ? '0 : r_presc + 1'b1;
      if (step_clr) r_step <= '0;
      else if (tick) r_step <= step ? '0 : r_step + 1'b1;
    end
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: arbitrates the LED bank between PS GPIO and PL patterns with PWM dimming;
// mode/brightness changes are accepted by handshake and committed on the next base tick.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int STEP_TICKS = 250,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [3:0]          gpio_leds,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_brightness,
  output logic [1:0]          mode_o,
  output logic [3:0]          leds_o
);
  cfg_state_e          r_state, w_state_nxt;
  led_mode_e           r_mode, r_pend_mode;
  logic [PWM_BITS-1:0] r_bri, r_pend_bri, r_pwm;
  logic [3:0]          r_chase, r_leds, w_src, w_chase_nxt;
  logic                r_dir, r_phase;
  logic                w_tick, w_step, w_accept, w_commit, w_pwm_on;

  led_tick_gen #(.TICK_DIV(TICK_DIV), .STEP_TICKS(STEP_TICKS)) u_tick (
    .clk(clk), .aresetn(aresetn), .step_clr(w_commit), .tick(w_tick), .step(w_step)
  );

  always_comb begin
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_state_nxt = r_state;
    w_accept    = r_state == CFG_RUN && cfg_valid;
    w_commit    = r_state == CFG_APPLY && w_tick;
    w_state_nxt = w_accept ? CFG_APPLY : w_commit ? CFG_RUN : r_state;
  end

  assign cfg_ready   = r_state == CFG_RUN;
  assign mode_o      = r_mode;
  assign leds_o      = r_leds;
  assign w_chase_nxt = r_dir ? r_chase << 1 : r_chase >> 1;
  assign w_pwm_on    = &r_bri || r_pwm < r_bri;
  assign w_src       = r_mode == LED_OFF   ? 4'b0000 :
                       r_mode == LED_PASS  ? gpio_leds :
                       r_mode == LED_CHASE ? r_chase : {4{r_phase}};

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      r_state     <= CFG_RUN;
      r_mode      <= LED_PASS;
      r_pend_mode <= LED_PASS;
      r_bri       <= '1;
      r_pend_bri  <= '1;
      r_pwm       <= '0;
      r_chase     <= CHASE_INIT;
      r_dir       <= 1'b1;
      r_phase     <= 1'b0;
      r_leds      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pwm   <= r_pwm + 1'b1;
      r_leds  <= w_pwm_on ? w_src : 4'b0000;
      if (w_accept) begin
        r_pend_mode <= led_mode_e'(cfg_mode);
        r_pend_bri  <= cfg_brightness;
      end
      // a commit restarts both patterns even when the mode is unchanged
      if (w_commit) begin
        r_mode  <= r_pend_mode;
        r_bri   <= r_pend_bri;
        r_chase <= CHASE_INIT;
        r_dir   <= 1'b1;
        r_phase <= 1'b1;
      end else if (w_step) begin
        r_chase <= w_chase_nxt;
        r_dir   <= w_chase_nxt[3] ? 1'b0 : w_chase_nxt[0] ? 1'b1 : r_dir;
        r_phase <= ~r_phase;
      end
    end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed and random stimulus checked every cycle against an arithmetic model.
module tb_led_mode_ctrl;
  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [3:0] gpio_leds = 4'h0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [1:0] cfg_brightness = 2'd0;
  logic       cfg_ready;
  logic [1:0] mode_o;
  logic [3:0] leds_o;

  int vectors = 0, errors = 0;

  led_mode_ctrl #(.TICK_DIV(4), .STEP_TICKS(2), .PWM_BITS(2)) dut (
    .clk(clk), .aresetn(aresetn), .gpio_leds(gpio_leds), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_brightness(cfg_brightness),
    .mode_o(mode_o), .leds_o(leds_o)
  );

  always #5 clk = ~clk;

  // model: everything derived from cycles since reset and steps since the last commit
  int   m_cyc = 0, m_ticks = 0, m_steps = 0;
  int   m_mode = 1, m_bri = 3, p_mode = 1, p_bri = 3;
  bit   m_busy = 0, m_blink0 = 0;
  logic [3:0] m_leds = 4'h0;
  int   chase_seq [6] = '{1, 2, 4, 8, 4, 2};

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_cyc <= 0; m_ticks <= 0; m_steps <= 0; m_busy <= 0; m_blink0 <= 0;
      m_mode <= 1; m_bri <= 3; p_mode <= 1; p_bri <= 3; m_leds <= 4'h0;
    end else begin
      bit tk, st, on, lit;
      logic [3:0] src;
      tk  = (m_cyc % 4) == 3;
      st  = tk && (m_ticks % 2) == 1;
      on  = m_bri == 3 || (m_cyc % 4) < m_bri;
      lit = m_blink0 != ((m_steps % 2) == 1);
      src = m_mode == 0 ? 4'h0 : m_mode == 1 ? gpio_leds :
            m_mode == 2 ? 4'(chase_seq[m_steps % 6]) : {4{lit}};
      m_leds <= on ? src : 4'h0;
      if (m_busy && tk) begin
        m_mode <= p_mode; m_bri <= p_bri; m_ticks <= 0; m_steps <= 0; m_blink0 <= 1; m_busy <= 0;
      end else begin
        if (st) m_steps <= m_steps + 1;
        if (tk) m_ticks <= m_ticks + 1;
      end
      if (!m_busy && cfg_valid) begin
        p_mode <= int'(cfg_mode); p_bri <= int'(cfg_brightness); m_busy <= 1;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_leds", 8'(leds_o), 8'(m_leds));
    chk("model_mode", 8'(mode_o), 8'(m_mode));
    chk("model_ready", 8'(cfg_ready), 8'(!m_busy));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic req(input int md, input int bri);
    cfg_valid = 1'b1; cfg_mode = 2'(md); cfg_brightness = 2'(bri);
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_mode(input int md, input int budget);
    int k = 0;
    while (mode_o != 2'(md) && k < budget) begin cyc(1); k++; end
    chk("wait_mode", 8'(mode_o), 8'(md));
  endtask

  task automatic count_on(input int n, input int exp, input string name);
    int c = 0;
    repeat (n) begin if (leds_o == 4'hF) c++; cyc(1); end
    chk(name, 8'(c), 8'(exp));
  endtask

  initial begin
    int seq7 [7] = '{1, 2, 4, 8, 4, 2, 1};
    int n;
    bit seen;
    gpio_leds = 4'hA;
    cyc(3);
    chk("reset_leds", 8'(leds_o), 8'h0);
    aresetn = 1'b1;
    cyc(1);
    chk("release_leds", 8'(leds_o), 8'hA);
    chk("release_mode", 8'(mode_o), 8'd1);
    chk("release_ready", 8'(cfg_ready), 8'd1);

    req(2, 3);
    chk("chase_ready_drop", 8'(cfg_ready), 8'd0);
    wait_mode(2, 20);
    cyc(1);
    for (int i = 0; i < 7; i++) begin
      chk("chase_seq", 8'(leds_o), 8'(seq7[i]));
      if (i < 6) cyc(8);
    end

    req(3, 3);
    wait_mode(3, 20);
    cyc(1);
    chk("blink_on0", 8'(leds_o), 8'hF);
    cyc(8);
    chk("blink_off", 8'(leds_o), 8'h0);
    cyc(8);
    chk("blink_on1", 8'(leds_o), 8'hF);

    gpio_leds = 4'hF;
    req(1, 1);
    wait_mode(1, 20);
    cyc(1);
    count_on(8, 2, "pwm_bri1");
    req(1, 0);
    cyc(10);
    count_on(8, 0, "pwm_bri0");
    req(1, 3);
    cyc(10);
    count_on(8, 8, "pwm_bri3");

    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_brightness = 2'd3;
    cyc(1);
    cfg_mode = 2'd3;
    chk("hs_ready_drop", 8'(cfg_ready), 8'd0);
    wait_mode(2, 20);
    cyc(1);
    cfg_valid = 1'b0;
    wait_mode(3, 20);

    req(1, 3);
    wait_mode(1, 20);
    n = 0;
    while ((m_cyc % 4) != 3 && n < 8) begin cyc(1); n++; end
    req(2, 3);
    n = 0;
    while (mode_o != 2'd2 && n < 10) begin cyc(1); n++; end
    chk("tick_coincident_delay", 8'(n), 8'd4);

    req(1, 3);
    wait_mode(1, 20);
    gpio_leds = 4'h5;
    req(2, 3);
    chk("mid_apply_busy", 8'(cfg_ready), 8'd0);
    aresetn = 1'b0;
    #1;
    chk("mid_reset_mode", 8'(mode_o), 8'd1);
    chk("mid_reset_ready", 8'(cfg_ready), 8'd1);
    chk("mid_reset_leds", 8'(leds_o), 8'h0);
    cyc(2);
    aresetn = 1'b1;
    seen = 0;
    repeat (40) begin cyc(1); if (mode_o == 2'd2) seen = 1; end
    chk("no_chase_after_reset", 8'(seen), 8'd0);
    chk("mid_reset_pass", 8'(leds_o), 8'h5);

    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) gpio_leds = 4'($urandom);
      cfg_valid = $urandom_range(0, 5) == 0;
      cfg_mode = 2'($urandom);
      cfg_brightness = 2'($urandom);
      aresetn = $urandom_range(0, 599) != 0;
      cyc(1);
      aresetn = 1'b1;
    end
    cfg_valid = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Owns the 4-bit board LED bank.
- Arbitrates the LEDs between the PS AXI GPIO output and two internal PL pattern generators (chase, blink).
- Applies global PWM dimming to whichever source is selected.
- Sits between the PS block-design GPIO output and the top-level LED pins, and is configured by a valid/ready mode/brightness handshake.

Parameters:
- TICK_DIV, 100000: clk cycles per base tick (1 kHz at 100 MHz).
- STEP_TICKS, 250: base ticks per pattern step.
- PWM_BITS, 4: width of the brightness value and of the PWM counter.

Ports:
- clk  input  1  fabric clock (PS FCLK).
- aresetn  input  1  reset. Asynchronous assert, active-low.
- gpio_leds  input  4  LED value from the PS GPIO, same clock domain.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  block can accept a configuration.
- cfg_mode  input  2  requested mode: 0 OFF, 1 PASS, 2 CHASE, 3 BLINK.
- cfg_brightness  input  PWM_BITS  requested duty.
- mode_o  output  2  currently committed mode.
- leds_o  output  4  registered LED drive.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (aresetn), with a synchronous deassert taken care of upstream.
- Reset values:
  - leds_o=0, cfg_ready=1, mode_o=PASS.
  - brightness = all ones; prescaler, step counter and PWM counter = 0.
  - chase pattern = 4'b0001, direction = up, blink phase = 0.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1. tick pulses for 1 cycle when the count equals TICK_DIV-1, then the count wraps to 0.
  - Step counter advances on tick, over 0..STEP_TICKS-1. step pulses (coincident with tick) when the count wraps.
- PWM:
  - pwm_cnt is a PWM_BITS-wide free-running counter, +1 every clk, wrapping naturally.
  - pwm_on = (brightness == all ones) OR (pwm_cnt < brightness).
  - brightness 0 means LEDs are always off. All ones means always on.
- Pattern sources (advance only on step):
  - CHASE bounces: 0001→0010→0100→1000→0100→0010→0001… Direction flips on reaching 1000 or 0001, and the end LED is not repeated.
  - BLINK: phase toggles on each step. Pattern is 1111 when phase=1, 0000 when phase=0.
- Output selection, registered, 1 cycle latency:
  - leds_o <= pwm_on ? src : 4'b0.
  - src = 0 (OFF), gpio_leds (PASS), chase pattern (CHASE), blink pattern (BLINK).
  - A gpio_leds change reaches leds_o on the next edge when PWM is fully on.
- Config FSM, states RUN and APPLY:
  - RUN: cfg_ready=1. When cfg_valid && cfg_ready: capture cfg_mode and cfg_brightness into pending registers, then go to APPLY.
  - APPLY: cfg_ready=0; cfg_valid is ignored. On the next tick:
    - commit the pending mode and brightness;
    - clear the step counter; chase ← 0001, direction up; blink phase ← 1 (BLINK starts lit);
    - return to RUN.
  - If the request is accepted in the same cycle as tick, commit happens on the following tick, never the same cycle.
  - Re-requesting the current mode still restarts its pattern.
  - mode_o changes in the same cycle as the commit.
- Any aresetn assertion, including mid-APPLY, discards the pending config and returns all state to the reset values immediately.
- No combinational path from any input to any output except none. cfg_ready is a pure state decode.

Decomposition:
- Package led_ctrl_pkg:
  - typedef enum logic [1:0] led_mode_e {LED_OFF, LED_PASS, LED_CHASE, LED_BLINK};
  - typedef enum cfg_state_e {CFG_RUN, CFG_APPLY};
  - constant CHASE_INIT = 4'b0001.
- Sub-module led_tick_gen:
  - Contains the prescaler and step counter.
  - Parameters TICK_DIV and STEP_TICKS; inputs clk, aresetn, step_clr; outputs tick, step.

Test Plan (bench parameters: TICK_DIV=4, STEP_TICKS=2, PWM_BITS=2):
- Reset:
  - Stimulus: hold aresetn=0 with gpio_leds=4'hA, then release.
  - Required: leds_o=0 during reset; leds_o=4'hA one cycle after release (PASS, brightness 3); mode_o=1; cfg_ready=1.
- CHASE commit:
  - Stimulus: cfg_valid with mode=2, brightness=3.
  - Required: cfg_ready drops the next cycle; mode_o=2 at the next tick; leds_o follows 0001,0010,0100,1000,0100,0010,0001, changing every 8 clks.
- BLINK:
  - Stimulus: mode=3.
  - Required: leds_o=1111 starting 1 cycle after commit, then alternates 0000/1111 every 8 clks.
- PWM:
  - Stimulus: PASS, gpio=4'hF, brightness=1.
  - Required: leds_o=F for exactly 1 of every 4 clks.
  - brightness=0 gives constant 0; brightness=3 gives constant F.
- Handshake and tick coincidence:
  - Stimulus: cfg_valid held high during APPLY with a different mode; separately, a request accepted on a tick cycle.
  - Required: the second request is not accepted until cfg_ready returns; the coincident request commits on the next tick, 4 clks later.
- Mid-APPLY reset:
  - Stimulus: assert aresetn while in APPLY with mode=2 pending.
  - Required: after release, mode_o=PASS, cfg_ready=1, and the chase never appears.
